// File: rtl/player_move.sv
// player_move: per-player grid movement controller. Walks tile-to-tile in
// frame-paced pixel steps after an obstacle query and emits bomb-drop requests.
module player_move #(
    parameter int GRID_W    = 15,
    parameter int GRID_H    = 13,
    parameter int TILE      = 32,
    parameter int STEP      = 2,
    parameter int START_COL = 1,
    parameter int START_ROW = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_drop,
    output logic       map_req,
    output logic [3:0] map_col,
    output logic [3:0] map_row,
    input  logic       map_ack,
    input  logic       map_solid,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [3:0] tile_col,
    output logic [3:0] tile_row,
    output logic [1:0] dir,
    output logic       moving,
    output logic       drop_req,
    output logic [3:0] drop_col,
    output logic [3:0] drop_row
);

    localparam int         TILE_SH = $clog2(TILE);
    localparam logic [9:0] HALF_PX = 10'(TILE / 2);
    localparam logic [9:0] STEP_PX = 10'(STEP);
    localparam logic [9:0] START_X = 10'(START_COL * TILE);
    localparam logic [9:0] START_Y = 10'(START_ROW * TILE);

    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_DOWN  = 2'd1;
    localparam logic [1:0] D_LEFT  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_QUERY,
        S_MOVE
    } state_t;

    state_t     r_state;
    logic [9:0] r_pos_x;
    logic [9:0] r_pos_y;
    logic [9:0] r_tgt_px;
    logic [1:0] r_dir;
    logic       r_moving;
    logic       r_map_req;
    logic [3:0] r_map_col;
    logic [3:0] r_map_row;
    logic       r_drop_prev;
    logic       r_drop_req;
    logic [3:0] r_drop_col;
    logic [3:0] r_drop_row;

    logic [3:0] w_tile_col;
    logic [3:0] w_tile_row;
    logic       w_any_btn;
    logic       w_in_range;
    logic [1:0] w_new_dir;
    logic [3:0] w_tgt_col;
    logic [3:0] w_tgt_row;
    logic [9:0] w_tgt_px;
    logic       w_vert;
    logic       w_neg;
    logic [9:0] w_axis_pos;
    logic [9:0] w_axis_nxt;

    // Nearest tile: round the top-left corner by half a tile.
    assign w_tile_col = 4'((r_pos_x + HALF_PX) >> TILE_SH);
    assign w_tile_row = 4'((r_pos_y + HALF_PX) >> TILE_SH);

    assign w_any_btn = btn_up | btn_down | btn_left | btn_right;

    always_comb begin
        w_new_dir  = D_RIGHT;
        w_tgt_col  = w_tile_col;
        w_tgt_row  = w_tile_row;
        w_in_range = 1'b0;
        if (btn_up) begin
            w_new_dir  = D_UP;
            w_tgt_row  = w_tile_row - 4'd1;
            w_in_range = (w_tile_row != 4'd0);
        end else if (btn_down) begin
            w_new_dir  = D_DOWN;
            w_tgt_row  = w_tile_row + 4'd1;
            w_in_range = (int'(w_tile_row) < GRID_H - 1);
        end else if (btn_left) begin
            w_new_dir  = D_LEFT;
            w_tgt_col  = w_tile_col - 4'd1;
            w_in_range = (w_tile_col != 4'd0);
        end else begin
            w_new_dir  = D_RIGHT;
            w_tgt_col  = w_tile_col + 4'd1;
            w_in_range = (int'(w_tile_col) < GRID_W - 1);
        end
    end

    assign w_tgt_px = ((w_new_dir == D_UP) || (w_new_dir == D_DOWN))
                      ? (10'(w_tgt_row) << TILE_SH)
                      : (10'(w_tgt_col) << TILE_SH);

    // The facing register is frozen during a move, so it selects axis and sign.
    assign w_vert     = (r_dir == D_UP) || (r_dir == D_DOWN);
    assign w_neg      = (r_dir == D_UP) || (r_dir == D_LEFT);
    assign w_axis_pos = w_vert ? r_pos_y : r_pos_x;
    assign w_axis_nxt = w_neg ? (w_axis_pos - STEP_PX) : (w_axis_pos + STEP_PX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_pos_x   <= START_X;
            r_pos_y   <= START_Y;
            r_tgt_px  <= 10'd0;
            r_dir     <= D_DOWN;
            r_moving  <= 1'b0;
            r_map_req <= 1'b0;
            r_map_col <= 4'd0;
            r_map_row <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (frame_tick && w_any_btn) begin
                        r_dir <= w_new_dir;
                        // Off-arena targets count as solid: no query is issued.
                        if (w_in_range) begin
                            r_map_col <= w_tgt_col;
                            r_map_row <= w_tgt_row;
                            r_map_req <= 1'b1;
                            r_tgt_px  <= w_tgt_px;
                            r_state   <= S_QUERY;
                        end
                    end
                end
                S_QUERY: begin
                    if (map_ack) begin
                        r_map_req <= 1'b0;
                        if (map_solid) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state  <= S_MOVE;
                            r_moving <= 1'b1;
                        end
                    end
                end
                S_MOVE: begin
                    if (frame_tick) begin
                        if (w_vert) begin
                            r_pos_y <= w_axis_nxt;
                        end else begin
                            r_pos_x <= w_axis_nxt;
                        end
                        if (w_axis_nxt == r_tgt_px) begin
                            r_state  <= S_IDLE;
                            r_moving <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_moving  <= 1'b0;
                    r_map_req <= 1'b0;
                end
            endcase
        end
    end

    // Drop request fires on the press edge only, independent of movement state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_prev <= 1'b0;
            r_drop_req  <= 1'b0;
            r_drop_col  <= 4'd0;
            r_drop_row  <= 4'd0;
        end else begin
            r_drop_prev <= btn_drop;
            r_drop_req  <= btn_drop & ~r_drop_prev;
            if (btn_drop && !r_drop_prev) begin
                r_drop_col <= w_tile_col;
                r_drop_row <= w_tile_row;
            end
        end
    end

    assign map_req  = r_map_req;
    assign map_col  = r_map_col;
    assign map_row  = r_map_row;
    assign pos_x    = r_pos_x;
    assign pos_y    = r_pos_y;
    assign tile_col = w_tile_col;
    assign tile_row = w_tile_row;
    assign dir      = r_dir;
    assign moving   = r_moving;
    assign drop_req = r_drop_req;
    assign drop_col = r_drop_col;
    assign drop_row = r_drop_row;

endmodule
